// File: rtl/sd_cmd_serial_host.sv
`default_nettype none
// ============================================================================
// sd_cmd_serial_host : shifts a 40-bit SD command plus CRC7 onto the CMD line
// and optionally captures and CRC-checks the card response.   Rev 1.0
// ============================================================================
module sd_cmd_serial_host (
    input  logic        CLK_PAD_IO,
    input  logic        RST_PAD_I,
    input  logic [15:0] SETTING_IN,
    input  logic [39:0] CMD_IN,
    input  logic        REQ_IN,
    input  logic        ACK_IN,
    output logic        ACK_OUT,
    output logic        REQ_OUT,
    output logic [39:0] CMD_OUT,
    output logic [7:0]  STATUS,
    input  logic        cmd_dat_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o
);
    localparam logic [5:0] NCR_LAST = 6'd63;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        DELAY    = 3'd2,
        WAIT_RSP = 3'd3,
        RECV     = 3'd4,
        REPORT   = 3'd5,
        FINISH   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_q;
    logic [47:0] tx_sr;
    logic [7:0]  bit_cnt;
    logic [2:0]  dly_cnt;
    logic [2:0]  dly_cfg;
    logic [5:0]  wait_cnt;
    logic        crc_en;
    logic [6:0]  rsp_size;
    logic [6:0]  crc_calc;
    logic [6:0]  crc_rx;
    logic        st_done;
    logic        st_crc_ok;
    logic        st_timeout;
    logic        req_rise;
    logic        rsp_long;
    logic        busy;
    logic [7:0]  crc_lo;
    logic [7:0]  last_bit;
    logic        unused_setting;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    assign req_rise       = REQ_IN & ~req_q;
    assign rsp_long       = (rsp_size == 7'd127);
    assign crc_lo         = rsp_long ? 8'd128 : 8'd40;
    assign last_bit       = rsp_long ? 8'd135 : 8'd47;
    assign unused_setting = &{1'b0, SETTING_IN[15:11]};
    assign STATUS         = {1'b0, st_done, st_crc_ok, st_timeout, 3'b000, busy};

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_oe_o  = 1'b0;
        cmd_out_o = 1'b1;
        REQ_OUT   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (req_rise) state_nxt = SEND;
            end
            SEND: begin
                cmd_oe_o  = 1'b1;
                cmd_out_o = tx_sr[47];
                busy      = 1'b1;
                if (bit_cnt == 8'd47) state_nxt = DELAY;
            end
            DELAY: begin
                cmd_oe_o = 1'b1;
                busy     = 1'b1;
                if (dly_cnt == dly_cfg) state_nxt = (rsp_size == 7'd0) ? REPORT : WAIT_RSP;
            end
            WAIT_RSP: begin
                busy = 1'b1;
                if (!cmd_dat_i) state_nxt = RECV;
                else if (wait_cnt == NCR_LAST) state_nxt = REPORT;
            end
            RECV: begin
                busy = 1'b1;
                if (bit_cnt == last_bit) state_nxt = REPORT;
            end
            REPORT: begin
                REQ_OUT = 1'b1;
                if (ACK_IN) state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            req_q      <= 1'b0;
            ACK_OUT    <= 1'b0;
            CMD_OUT    <= 40'h0;
            tx_sr      <= 48'h0;
            bit_cnt    <= 8'h0;
            dly_cnt    <= 3'h0;
            dly_cfg    <= 3'h0;
            wait_cnt   <= 6'h0;
            crc_en     <= 1'b0;
            rsp_size   <= 7'h0;
            crc_calc   <= 7'h0;
            crc_rx     <= 7'h0;
            st_done    <= 1'b0;
            st_crc_ok  <= 1'b0;
            st_timeout <= 1'b0;
        end else begin
            req_q   <= REQ_IN;
            ACK_OUT <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (req_rise) begin
                        tx_sr      <= {CMD_IN, crc7_40(CMD_IN), 1'b1};
                        dly_cfg    <= SETTING_IN[10:8];
                        crc_en     <= SETTING_IN[7];
                        rsp_size   <= SETTING_IN[6:0];
                        bit_cnt    <= 8'h0;
                        st_done    <= 1'b0;
                        st_crc_ok  <= 1'b0;
                        st_timeout <= 1'b0;
                    end
                end
                SEND: begin
                    tx_sr   <= {tx_sr[46:0], 1'b0};
                    bit_cnt <= bit_cnt + 8'd1;
                    dly_cnt <= 3'h0;
                end
                DELAY: begin
                    dly_cnt  <= dly_cnt + 3'd1;
                    wait_cnt <= 6'h0;
                    if (dly_cnt == dly_cfg && rsp_size == 7'd0) begin
                        st_done   <= 1'b1;
                        st_crc_ok <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (!cmd_dat_i) begin
                        // The start bit is frame bit 0; the CRC of a zero bit from zero stays zero.
                        CMD_OUT  <= {CMD_OUT[38:0], 1'b0};
                        crc_calc <= 7'h0;
                        crc_rx   <= 7'h0;
                        bit_cnt  <= 8'd1;
                    end else if (wait_cnt == NCR_LAST) begin
                        st_timeout <= 1'b1;
                        st_done    <= 1'b0;
                        st_crc_ok  <= ~crc_en;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                RECV: begin
                    bit_cnt <= bit_cnt + 8'd1;
                    if (bit_cnt < crc_lo) begin
                        CMD_OUT <= {CMD_OUT[38:0], cmd_dat_i};
                        if (!rsp_long || bit_cnt >= 8'd8) crc_calc <= crc7_step(crc_calc, cmd_dat_i);
                    end else if (bit_cnt < crc_lo + 8'd7) begin
                        crc_rx <= {crc_rx[5:0], cmd_dat_i};
                    end
                    if (bit_cnt == last_bit) begin
                        st_done   <= 1'b1;
                        st_crc_ok <= ~crc_en | (crc_rx == crc_calc);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire
